// File: rtl/mcpu5_host_if.sv
// Signal bundle between mcpu5_host, the MCPU5 core pins and the host-side control/result logic.
interface mcpu5_host_if #(
  parameter int PROG_AW = 6
);
  logic               start;
  logic               halt;
  logic               load_we;
  logic [PROG_AW-1:0] load_addr;
  logic [5:0]         load_data;
  logic               cpu_clk;
  logic               cpu_rst;
  logic [5:0]         cpu_inst;
  logic [7:0]         cpu_out;
  logic               out_valid;
  logic [7:0]         out_data;
  logic [7:0]         pc_mon;
  logic               running;
  logic [15:0]        instr_cnt;

  modport master (
    input  start, halt, load_we, load_addr, load_data, cpu_out,
    output cpu_clk, cpu_rst, cpu_inst, out_valid, out_data, pc_mon, running, instr_cnt
  );

  modport slave (
    output start, halt, load_we, load_addr, load_data, cpu_out,
    input  cpu_clk, cpu_rst, cpu_inst, out_valid, out_data, pc_mon, running, instr_cnt
  );
endinterface

// File: rtl/mcpu5_host.sv
// MCPU5 host sequencer: derives core clock/reset, feeds instructions from program memory, captures OUT results.
//   state   | meaning
//   S_IDLE  | core clock parked high, program memory writable
//   S_RESET | three DIV-long phases (L,H,L) with core reset asserted
//   S_HIGH  | core clock high; PC read and instruction fetched
//   S_LOW   | core clock low; instruction held, accumulator visible
module mcpu5_host #(
  parameter int DIV     = 4,
  parameter int PROG_AW = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  mcpu5_host_if.master bus
);
  localparam int             CW       = $clog2(DIV);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(DIV - 1);
  localparam logic [5:0]     NOP      = 6'b111011;
  localparam logic [5:0]     OUT      = 6'b111001;

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_HIGH, S_LOW} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rph_q, rph_d;
  logic          halt_req_q, halt_req_d;
  logic          cpu_clk_q, cpu_clk_d;
  logic          cpu_rst_q, cpu_rst_d;
  logic [5:0]    cpu_inst_q, cpu_inst_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic [7:0]    pc_mon_q, pc_mon_d;
  logic          running_q, running_d;
  logic [15:0]   instr_cnt_q, instr_cnt_d;
  logic          mem_we;
  logic [5:0]    mem_rd;
  logic [5:0]    mem_q [2**PROG_AW];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rph_d       = rph_q;
    halt_req_d  = halt_req_q;
    cpu_clk_d   = cpu_clk_q;
    cpu_rst_d   = cpu_rst_q;
    cpu_inst_d  = cpu_inst_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    pc_mon_d    = pc_mon_q;
    instr_cnt_d = instr_cnt_q;
    mem_we      = 1'b0;
    mem_rd      = mem_q[bus.cpu_out[PROG_AW-1:0]];
    case (state_q)
      S_IDLE: begin
        cpu_clk_d = 1'b1;
        mem_we    = bus.load_we;
        if (bus.start) begin
          state_d    = S_RESET;
          cnt_d      = CNT_LOAD;
          rph_d      = 2'd0;
          cpu_clk_d  = 1'b0;
          cpu_rst_d  = 1'b1;
          cpu_inst_d = NOP;
          halt_req_d = bus.halt;
        end
      end
      S_RESET: begin
        if (bus.halt) halt_req_d = 1'b1;
        if (cnt_q == '0) begin
          cnt_d = CNT_LOAD;
          if (rph_q == 2'd2) begin
            state_d   = S_HIGH;
            cpu_clk_d = 1'b1;
          end else begin
            rph_d     = rph_q + 2'd1;
            cpu_clk_d = ~cpu_clk_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HIGH: begin
        cpu_rst_d = 1'b0;
        if (bus.halt) halt_req_d = 1'b1;
        // one clk before the fall, so the core has had time to present its PC
        if (cnt_q == CW'(1)) begin
          pc_mon_d   = bus.cpu_out;
          cpu_inst_d = mem_rd;
        end
        if (cnt_q == '0) begin
          cnt_d = CNT_LOAD;
          if (halt_req_q) begin
            halt_req_d = 1'b0;
            cpu_inst_d = NOP;
            state_d    = S_IDLE;
          end else begin
            cpu_clk_d = 1'b0;
            state_d   = S_LOW;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_LOW: begin
        if (bus.halt) halt_req_d = 1'b1;
        if (cnt_q == '0) begin
          cnt_d       = CNT_LOAD;
          cpu_clk_d   = 1'b1;
          instr_cnt_d = instr_cnt_q + 16'd1;
          state_d     = S_HIGH;
          if (cpu_inst_q == OUT) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.cpu_out;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    running_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rph_q       <= 2'd0;
      halt_req_q  <= 1'b0;
      cpu_clk_q   <= 1'b1;
      cpu_rst_q   <= 1'b1;
      cpu_inst_q  <= NOP;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      pc_mon_q    <= 8'd0;
      running_q   <= 1'b0;
      instr_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rph_q       <= rph_d;
      halt_req_q  <= halt_req_d;
      cpu_clk_q   <= cpu_clk_d;
      cpu_rst_q   <= cpu_rst_d;
      cpu_inst_q  <= cpu_inst_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      pc_mon_q    <= pc_mon_d;
      running_q   <= running_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // program memory keeps its contents across resets
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[bus.load_addr] <= bus.load_data;
  end

  assign bus.cpu_clk   = cpu_clk_q;
  assign bus.cpu_rst   = cpu_rst_q;
  assign bus.cpu_inst  = cpu_inst_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.pc_mon    = pc_mon_q;
  assign bus.running   = running_q;
  assign bus.instr_cnt = instr_cnt_q;
endmodule

// File: doc/mcpu5_host.md
# mcpu5_host

Host sequencer for the MCPU5 core, running on the fast system clock. It derives the core's clock and reset, owns a loadable program memory, and fetches instructions by reading the PC the core presents on its multiplexed output while its clock is high. It drives each instruction back to the core and captures the accumulator whenever an OUT instruction executes. It sits directly upstream (instruction feed) and downstream (output demux) of the core.

## Interface

Parameters:
- DIV, 4: system clocks per core-clock half-phase; must be at least 2.
- PROG_AW, 6: program memory address width; depth is 2^PROG_AW words of 6 bits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; in IDLE, starts a core-reset-then-run sequence.
- halt  in  1  pulse; requests a stop at the end of the current HIGH phase.
- load_we  in  1  program write strobe; honoured only in IDLE.
- load_addr  in  PROG_AW  program write address.
- load_data  in  6  program word.
- cpu_clk  out  1  core clock.
- cpu_rst  out  1  core reset, active-high (synchronous inside the core).
- cpu_inst  out  6  instruction to the core.
- cpu_out  in  8  core output: PC while cpu_clk=1, accumulator while cpu_clk=0.
- out_valid  out  1  one-clk pulse; out_data updated.
- out_data  out  8  accumulator value captured at OUT.
- pc_mon  out  8  last PC sampled from the core.
- running  out  1  high in states RESET, HIGH and LOW.
- instr_cnt  out  16  count of executed core cycles; wraps.

## Operation

- All outputs are registered.
- On rst_n low, the block goes to IDLE with:
  - cpu_clk=1, cpu_rst=1, cpu_inst=6'b111011 (NOP);
  - out_valid=0, out_data=0, pc_mon=0, instr_cnt=0, running=0;
  - halt request cleared.
- Program memory is not reset.
- States:
  - IDLE: cpu_clk is held at 1. load_we writes mem[load_addr] <= load_data. start moves to RESET and drives cpu_clk to 0 on the same edge. halt is ignored. If start and load_we arrive together, the write happens and start is also taken.
  - RESET: cpu_rst=1, cpu_inst=NOP. Runs three phases of DIV clks each: L, H, L. This gives two core rising edges with reset asserted. The second rising edge (end of the final L) enters HIGH with count 0. cpu_rst drops to 0 on the next clk.
  - HIGH (cpu_clk=1):
    - At count DIV-2: pc_mon <= cpu_out and cpu_inst <= mem[cpu_out[PROG_AW-1:0]]. PC values above the memory depth alias (wrap).
    - At count DIV-1: if a halt request is pending, clear it, set cpu_inst <= NOP and go to IDLE with cpu_clk kept at 1. Otherwise set cpu_clk <= 0 and go to LOW.
  - LOW (cpu_clk=0): cpu_inst is held stable for the whole phase, which keeps the core's STA register write clean. At count DIV-1:
    - cpu_clk <= 1;
    - instr_cnt += 1;
    - if cpu_inst == 6'b111001 (OUT), out_data <= cpu_out and out_valid <= 1 for one clk;
    - go to HIGH.
- halt is latched as a sticky request in RESET, HIGH and LOW. If it arrives during RESET, the reset sequence completes and the block stops at the end of the first HIGH phase.
- start outside IDLE is ignored. load_we outside IDLE is ignored and memory is unchanged.
- A restart always re-resets the core, so the PC restarts at 0.

## Timing

- Core cycle = 2*DIV clks. The first fetch (PC 0) happens DIV-2 clks into the first HIGH phase.
- cpu_inst changes only while cpu_clk=1, and never on the same edge as a cpu_clk transition.
- out_valid rises on the same edge as the cpu_clk rise that executes the OUT. out_data is the accumulator before execution.
- Start to first fetch = 1 + 3*DIV + (DIV-2) clks: the start edge, the three RESET phases, then DIV-2 clks into HIGH.
- Halt latency: the block stops at the end of the current or next HIGH phase, at most 2*DIV clks after the request. running falls on the edge that enters IDLE.
- Asynchronous reset mid-phase: every output takes its reset value immediately and the phase counter returns to 0.

## Test plan

- Reset: assert rst_n=0 mid-LOW -> cpu_clk=1, cpu_rst=1, cpu_inst=6'b111011, running=0, out_valid=0, instr_cnt=0 while reset is held.
- OUT loop: load 010101, 111001, 001111; pulse start -> out_valid every 4*DIV clks with out_data=8'h05. pc_mon alternates 8'h01/8'h02 after the first pass.
- ALU path: load LDI 3 (010011), STA r0 (101000), ADD r0 (100000), OUT (111001) -> first out_data=8'h06 after 4 core cycles; instr_cnt=4 at that point.
- PC wrap: load LDI 0 (010000), LDI 4 (010100), JMPA (111010) -> pc_mon=8'h40 and the next fetch uses mem[0], so cpu_inst=6'b010000.
- Halt/restart: pulse halt mid-LOW -> stop with cpu_clk=1 and running=0 within 2*DIV clks; load_we while running leaves memory unchanged; start -> cpu_rst re-asserted and pc_mon=8'h00 at the first fetch.
- Boundaries: DIV=2 build; start and halt in the same IDLE cycle -> runs, then stops after the first HIGH phase.
